// File: rtl/map_rmw_arbiter_if.sv
// rtl/map_rmw_arbiter_if.sv - requester and map_RAM port-B bundle for map_rmw_arbiter
//
// Groups the tile-update request bus and the map_RAM port-B bus.
// Ports, as seen from the master (arbiter) side:
//   req, req_x, req_y, req_tile  in   per-requester request level and packed x/y/tile
//   hold                         in   1 = arbiter issues no new grants
//   done                         out  one-hot completion pulse
//   old_tile, err                out  result, valid while done != 0
//   busy                         out  arbiter is not idle
//   ram_addr, ram_wrdata,
//   ram_wren                     out  map_RAM port B address, write data, write enable
//   ram_rddata                   in   map_RAM port B read data
// The slave modport is the requesters/RAM side of the same bundle.
interface map_rmw_arbiter_if #(
  parameter int COLS   = 40,
  parameter int TILE_W = 4,
  parameter int N_REQ  = 3
);
  localparam int ROW_W = COLS * TILE_W;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*6-1:0]      req_x;
  logic [N_REQ*5-1:0]      req_y;
  logic [N_REQ*TILE_W-1:0] req_tile;
  logic                    hold;
  logic [N_REQ-1:0]        done;
  logic [TILE_W-1:0]       old_tile;
  logic                    err;
  logic                    busy;
  logic [4:0]              ram_addr;
  logic [ROW_W-1:0]        ram_wrdata;
  logic                    ram_wren;
  logic [ROW_W-1:0]        ram_rddata;

  modport master (
    input  req, req_x, req_y, req_tile, hold, ram_rddata,
    output done, old_tile, err, busy, ram_addr, ram_wrdata, ram_wren
  );

  modport slave (
    output req, req_x, req_y, req_tile, hold, ram_rddata,
    input  done, old_tile, err, busy, ram_addr, ram_wrdata, ram_wren
  );
endinterface

// File: rtl/map_rmw_arbiter.sv
// rtl/map_rmw_arbiter.sv - round-robin read-modify-write arbiter for map_RAM port B
//
// Shares map_RAM port B between N_REQ tile-update requesters (0 pacman,
// 1 ghost1, 2 ghost2). Each grant performs one atomic read-modify-write of
// a single TILE_W-bit tile code and returns the previous code.
// Ports:
//   CLOCK_50  in   system clock
//   reset     in   asynchronous, active-high
//   bus       map_rmw_arbiter_if.master: request bus, result, map_RAM port B
module map_rmw_arbiter #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int TILE_W = 4,
  parameter int RD_LAT = 1,
  parameter int N_REQ  = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  map_rmw_arbiter_if.master bus
);
  localparam int ROW_W = COLS * TILE_W;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  rr_last_q;
  logic [5:0]        x_q;
  logic [TILE_W-1:0] tile_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [N_REQ-1:0]  done_q;
  logic [TILE_W-1:0] old_tile_q;
  logic              err_q;
  logic              busy_q;
  logic [4:0]        ram_addr_q;
  logic [ROW_W-1:0]  ram_wrdata_q;
  logic              ram_wren_q;

  // Round-robin pick: offsets are scanned from farthest to nearest so the
  // requester closest after rr_last_q is the last one assigned and wins.
  logic              gnt_vld_d;
  logic [IDX_W-1:0]  gnt_idx_d;
  logic [IDX_W-1:0]  cand_d;
  logic [5:0]        gnt_x_d;
  logic [4:0]        gnt_y_d;
  logic [TILE_W-1:0] gnt_tile_d;
  logic              gnt_oob_d;

  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_idx_d = '0;
    cand_d    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_d = IDX_W'((int'(rr_last_q) + k) % N_REQ);
      if (bus.req[cand_d]) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = cand_d;
      end
    end
    gnt_x_d    = '0;
    gnt_y_d    = '0;
    gnt_tile_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx_d == IDX_W'(i)) begin
        gnt_x_d    = bus.req_x[6*i +: 6];
        gnt_y_d    = bus.req_y[5*i +: 5];
        gnt_tile_d = bus.req_tile[TILE_W*i +: TILE_W];
      end
    end
    gnt_oob_d = (int'(gnt_x_d) >= COLS) || (int'(gnt_y_d) >= ROWS);
  end

  // Column 0 sits in the most significant slice of the row. The merged row
  // is built straight from q_b so that the write data register doubles as
  // the captured row.
  logic [ROW_W-1:0]  merged_d;
  logic [TILE_W-1:0] old_d;

  always_comb begin
    merged_d = bus.ram_rddata;
    old_d    = '0;
    for (int c = 0; c < COLS; c++) begin
      if (x_q == 6'(c)) begin
        old_d = bus.ram_rddata[ROW_W - TILE_W*(c+1) +: TILE_W];
        merged_d[ROW_W - TILE_W*(c+1) +: TILE_W] = tile_q;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      rr_last_q    <= IDX_W'(N_REQ - 1);
      x_q          <= '0;
      tile_q       <= '0;
      rd_cnt_q     <= '0;
      done_q       <= '0;
      old_tile_q   <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      ram_addr_q   <= '0;
      ram_wrdata_q <= '0;
      ram_wren_q   <= 1'b0;
    end else begin
      done_q     <= '0;
      ram_wren_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!bus.hold && gnt_vld_d) begin
            idx_q      <= gnt_idx_d;
            rr_last_q  <= gnt_idx_d;
            x_q        <= gnt_x_d;
            tile_q     <= gnt_tile_d;
            ram_addr_q <= gnt_y_d;
            rd_cnt_q   <= '0;
            busy_q     <= 1'b1;
            if (gnt_oob_d) begin
              // Out-of-range coordinate: answer at once, never touch the RAM.
              err_q      <= 1'b1;
              old_tile_q <= '0;
              done_q     <= N_REQ'(1) << gnt_idx_d;
              state_q    <= S_ACK;
            end else begin
              err_q   <= 1'b0;
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          // RD_LAT+1 cycles with ram_addr stable; q_b is valid on the last.
          if (rd_cnt_q == CNT_W'(RD_LAT)) begin
            ram_wrdata_q <= merged_d;
            old_tile_q   <= old_d;
            ram_wren_q   <= 1'b1;
            state_q      <= S_WR;
          end else begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          end
        end
        S_WR: begin
          done_q  <= N_REQ'(1) << idx_q;
          state_q <= S_ACK;
        end
        S_ACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.done       = done_q;
  assign bus.old_tile   = old_tile_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wrdata = ram_wrdata_q;
  assign bus.ram_wren   = ram_wren_q;
endmodule

// File: tb/tb_map_rmw_arbiter.sv
// tb/tb_map_rmw_arbiter.sv - scoreboard bench for map_rmw_arbiter
module tb_map_rmw_arbiter;
  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int TW    = 4;
  localparam int N     = 3;
  localparam int ROW_W = COLS * TW;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  map_rmw_arbiter_if #(.COLS(COLS), .TILE_W(TW), .N_REQ(N)) ifc ();

  map_rmw_arbiter #(.COLS(COLS), .ROWS(ROWS), .TILE_W(TW), .RD_LAT(1), .N_REQ(N)) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (ifc)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string nm, logic [ROW_W-1:0] act, logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // map_RAM port B: one-cycle registered read, write on wren
  logic [ROW_W-1:0] ram_mem [32];
  always @(posedge CLOCK_50) begin
    ifc.ram_rddata <= ram_mem[ifc.ram_addr];
    if (ifc.ram_wren) ram_mem[ifc.ram_addr] = ifc.ram_wrdata;
  end

  // Reference: the map as a grid of tile codes
  int tiles [ROWS][COLS];

  function automatic logic [ROW_W-1:0] row_of(int y);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int x = 0; x < COLS; x++) r = (r << TW) | ROW_W'(tiles[y][x]);
    return r;
  endfunction

  typedef struct { int idx; int old; bit err; int cyc; } done_t;
  typedef struct { int addr; logic [ROW_W-1:0] row; int cyc; } wr_t;
  done_t exp_done[$];
  wr_t   exp_wr[$];
  int    served[$];

  int cyc = 0;
  int m_rr = N - 1, m_free = 0, busy_lo = 1, busy_hi = 0;
  bit pend_v = 0;
  int pend_x, pend_y, pend_t, pend_cyc;
  int w, gx, gy, gt, old;
  logic [ROW_W-1:0] r;

  // Model: a grant is possible once the previous op's ACK has passed.
  // Normal op: write in cycle G+2, done in G+3; error op: done in G.
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_rr = N - 1; m_free = 0; pend_v = 0; busy_lo = 1; busy_hi = 0;
      exp_done.delete(); exp_wr.delete();
    end else begin
      cyc = cyc + 1;
      if (pend_v && cyc == pend_cyc) begin
        tiles[pend_y][pend_x] = pend_t;
        pend_v = 0;
      end
      if (cyc >= m_free && !ifc.hold && ifc.req != 0) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && ifc.req[(m_rr + k) % N]) w = (m_rr + k) % N;
        gx = int'(ifc.req_x[6*w +: 6]);
        gy = int'(ifc.req_y[5*w +: 5]);
        gt = int'(ifc.req_tile[TW*w +: TW]);
        m_rr = w;
        if (gx >= COLS || gy >= ROWS) begin
          exp_done.push_back('{idx: w, old: 0, err: 1'b1, cyc: cyc});
          busy_lo = cyc; busy_hi = cyc; m_free = cyc + 2;
        end else begin
          old = tiles[gy][gx];
          tiles[gy][gx] = gt;
          r = row_of(gy);
          tiles[gy][gx] = old;
          exp_wr.push_back('{addr: gy, row: r, cyc: cyc + 2});
          exp_done.push_back('{idx: w, old: old, err: 1'b0, cyc: cyc + 3});
          pend_v = 1; pend_x = gx; pend_y = gy; pend_t = gt; pend_cyc = cyc + 3;
          busy_lo = cyc; busy_hi = cyc + 3; m_free = cyc + 5;
        end
      end
    end
  end

  // Monitor
  done_t ed;
  wr_t   ew;
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (ifc.done != 0) begin
        for (int i = 0; i < N; i++) if (ifc.done[i]) served.push_back(i);
        if (exp_done.size() == 0) chk("done_unexpected", ifc.done, 0);
        else begin
          ed = exp_done.pop_front();
          chk("done_vec", ifc.done, N'(1) << ed.idx);
          chk("old_tile", ifc.old_tile, ed.old);
          chk("err", ifc.err, ed.err);
          chk("done_cycle", cyc, ed.cyc);
        end
      end else if (exp_done.size() != 0 && exp_done[0].cyc <= cyc) begin
        ed = exp_done.pop_front();
        chk("done_missing", ifc.done, N'(1) << ed.idx);
      end
      if (ifc.ram_wren) begin
        if (exp_wr.size() == 0) chk("wren_unexpected", ifc.ram_wren, 0);
        else begin
          ew = exp_wr.pop_front();
          chk("wr_addr", ifc.ram_addr, ew.addr);
          chk("wr_data", ifc.ram_wrdata, ew.row);
          chk("wr_cycle", cyc, ew.cyc);
        end
      end else if (exp_wr.size() != 0 && exp_wr[0].cyc <= cyc) begin
        ew = exp_wr.pop_front();
        chk("wren_missing", ifc.ram_wren, 1);
      end
      chk("busy", ifc.busy, (cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  // Requester driver: drop req on own done; in auto mode re-raise randomly
  bit auto_mode = 0;
  int cool [N];
  task automatic rnd_coords(int i);
    ifc.req_x[6*i +: 6]     = 6'($urandom_range(0, 47));
    ifc.req_y[5*i +: 5]     = 5'($urandom_range(0, 31));
    ifc.req_tile[TW*i +: TW] = TW'($urandom_range(0, 15));
  endtask

  always @(negedge CLOCK_50) begin
    for (int i = 0; i < N; i++) begin
      if (ifc.done[i]) begin
        ifc.req[i] = 1'b0;
        cool[i] = $urandom_range(0, 6);
      end else if (auto_mode && !ifc.req[i]) begin
        if (cool[i] > 0) cool[i]--;
        else if ($urandom_range(0, 2) == 0) begin
          rnd_coords(i);
          ifc.req[i] = 1'b1;
        end
      end else if (auto_mode && $urandom_range(0, 4) == 0) begin
        rnd_coords(i);
      end
    end
  end

  task automatic load(int i, int x, int y, int t);
    ifc.req_x[6*i +: 6]      = 6'(x);
    ifc.req_y[5*i +: 5]      = 5'(y);
    ifc.req_tile[TW*i +: TW] = TW'(t);
  endtask

  task automatic raise(logic [N-1:0] m);
    @(negedge CLOCK_50); #1;
    ifc.req = ifc.req | m;
  endtask

  task automatic wait_quiet(string nm, int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge CLOCK_50); #1;
      if (ifc.req == 0 && !ifc.busy) break;
    end
    chk(nm, {ifc.busy, ifc.req}, 0);
  endtask

  task automatic wait_served(string nm, int n, int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge CLOCK_50); #1;
      if (served.size() >= n) break;
    end
    chk(nm, served.size() >= n, 1);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50); reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  function automatic int sv(int i);
    return (i < served.size()) ? served[i] : -1;
  endfunction

  int s0;
  initial begin
    ifc.req = '0; ifc.req_x = '0; ifc.req_y = '0; ifc.req_tile = '0; ifc.hold = 1'b0;
    for (int i = 0; i < N; i++) cool[i] = 0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) tiles[y][x] = $urandom_range(0, 15);
    tiles[1][0] = 2;
    for (int y = 0; y < 32; y++) ram_mem[y] = (y < ROWS) ? row_of(y) : '0;

    repeat (3) @(negedge CLOCK_50);
    chk("rst_done", ifc.done, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_wren", ifc.ram_wren, 0);
    chk("rst_addr", ifc.ram_addr, 0);
    chk("rst_old", ifc.old_tile, 0);
    chk("rst_err", ifc.err, 0);
    chk("rst_wrdata", ifc.ram_wrdata, 0);
    reset = 1'b0;

    // T1 / T2: corner columns
    load(0, 0, 1, 4); raise(3'b001);
    wait_quiet("t1_quiet", 50);
    chk("t1_ram_row", ram_mem[1], row_of(1));
    chk("t1_tile", tiles[1][0], 4);
    load(1, 39, 29, 15); raise(3'b010);
    wait_quiet("t2_quiet", 50);
    chk("t2_ram_row", ram_mem[29], row_of(29));

    // T3: round-robin order
    do_reset(); served.delete();
    load(0, 3, 4, 1); load(1, 5, 6, 2); load(2, 7, 8, 3);
    raise(3'b111);
    wait_quiet("t3_quiet", 100);
    chk("t3_ord0", sv(0), 0); chk("t3_ord1", sv(1), 1); chk("t3_ord2", sv(2), 2);
    served.delete();
    raise(3'b011);
    wait_served("t3_first", 1, 50);
    raise(3'b001);
    wait_quiet("t3b_quiet", 100);
    chk("t3b_ord0", sv(0), 0); chk("t3b_ord1", sv(1), 1); chk("t3b_ord2", sv(2), 0);

    // T4: out-of-range column, then rr_last=2 means 0 is next
    served.delete();
    load(2, 40, 5, 7); raise(3'b100);
    wait_quiet("t4_quiet", 50);
    raise(3'b111);
    wait_quiet("t4b_quiet", 100);
    chk("t4_ord0", sv(0), 2); chk("t4_ord1", sv(1), 0);
    chk("t4_ord2", sv(2), 1); chk("t4_ord3", sv(3), 2);

    // T5: hold blocks new grants
    served.delete();
    @(negedge CLOCK_50); #1; ifc.hold = 1'b1;
    load(0, 12, 13, 6); raise(3'b001);
    repeat (10) begin
      @(negedge CLOCK_50); #1;
      chk("t5_busy", ifc.busy, 0);
      chk("t5_wren", ifc.ram_wren, 0);
    end
    ifc.hold = 1'b0;
    wait_quiet("t5_quiet", 50);
    chk("t5_served", sv(0), 0);

    // T6: reset during the write cycle
    s0 = served.size();
    load(0, 10, 3, 9); raise(3'b001);
    for (int k = 0; k < 50; k++) begin
      @(negedge CLOCK_50);
      if (ifc.ram_wren) break;
    end
    chk("t6_saw_wren", ifc.ram_wren, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_wren_drop", ifc.ram_wren, 0);
    chk("t6_busy", ifc.busy, 0);
    chk("t6_done", ifc.done, 0);
    chk("t6_row_untouched", ram_mem[3], row_of(3));
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    wait_quiet("t6_quiet", 50);
    chk("t6_one_done", served.size(), s0 + 1);
    chk("t6_ram_row", ram_mem[3], row_of(3));
    chk("t6_tile", tiles[3][10], 9);

    // Random traffic
    auto_mode = 1;
    repeat (3000) begin
      @(negedge CLOCK_50); #1;
      ifc.hold = ($urandom_range(0, 9) == 0);
    end
    auto_mode = 0;
    ifc.hold = 1'b0;
    wait_quiet("rnd_quiet", 400);
    repeat (3) @(negedge CLOCK_50);
    for (int y = 0; y < ROWS; y++) chk($sformatf("final_row%0d", y), ram_mem[y], row_of(y));
    chk("done_left", exp_done.size(), 0);
    chk("wr_left", exp_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
